// File: rtl/math_game_pkg.sv
// Shared types and display/LED codes for the mental-arithmetic game controller.
package math_game_pkg;

    typedef enum logic [2:0] {
        IDLE, CLR, GEN, BLANK, ANSWER, CHECK, RESULT, DONE
    } state_e;

    localparam logic [1:0] DISP_BLANK   = 2'd0;
    localparam logic [1:0] DISP_OPERAND = 2'd1;
    localparam logic [1:0] DISP_SWITCH  = 2'd2;
    localparam logic [1:0] DISP_SUM     = 2'd3;

    localparam logic [1:0] LED_OFF      = 2'd0;
    localparam logic [1:0] LED_OPERAND  = 2'd1;
    localparam logic [1:0] LED_CORRECT  = 2'd2;
    localparam logic [1:0] LED_WRONG    = 2'd3;

    localparam logic [6:0] LED_WRONG_PATTERN = 7'b1010101;

endpackage

// File: rtl/phase_timer.sv
// 8-bit loadable down-counter; expire marks the last cycle of a phase,
// including the load cycle itself when the phase is one cycle long.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       expire_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i - 8'd1;
        else if (cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
    end

    assign expire_o = load_i ? (load_val_i == 8'd1) : (cnt_q == 8'd1);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/math_game_sequencer.sv
// Round/game controller: sequences the operand datapath and drives display
// and LED selects as registered decodes of the next state.
module math_game_sequencer
    import math_game_pkg::*;
#(
    parameter int NUM_OPERANDS  = 5,
    parameter int SHOW_CYCLES   = 1,
    parameter int ANSWER_CYCLES = 15,
    parameter int RESULT_CYCLES = 4,
    parameter int ROUNDS        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [6:0] switch,
    input  logic [6:0] sum_mod,
    output logic       sum_clr,
    output logic       lfsr_step,
    output logic [1:0] disp_sel,
    output logic [1:0] led_mode,
    output logic [2:0] score,
    output logic [2:0] round_idx,
    output logic       busy,
    output logic       game_done
);
    if (ROUNDS < 1 || ROUNDS > 7) begin : g_bad_rounds
        $error("ROUNDS must be in 1..7");
    end
    if (NUM_OPERANDS < 1 || NUM_OPERANDS > 15) begin : g_bad_ops
        $error("NUM_OPERANDS must be in 1..15");
    end

    localparam logic [3:0] LAST_OP    = 4'(NUM_OPERANDS - 1);
    localparam logic [2:0] LAST_ROUND = 3'(ROUNDS - 1);
    localparam logic [2:0] FULL_SCORE = 3'(ROUNDS);

    state_e     state_q, state_d;
    logic       first_q, first_d;
    logic [3:0] op_q, op_d;
    logic [2:0] round_q, round_d, score_q, score_d;
    logic       correct_q, correct_d;
    logic       tmr_load, tmr_expire;
    logic [7:0] tmr_val;
    logic [1:0] disp_d, led_d;

    // first_q marks the opening cycle of a timed phase or GEN slot
    assign tmr_load = first_q && (state_q inside {GEN, ANSWER, RESULT});

    always_comb begin
        case (state_q)
            GEN:     tmr_val = 8'(SHOW_CYCLES);
            ANSWER:  tmr_val = 8'(ANSWER_CYCLES);
            default: tmr_val = 8'(RESULT_CYCLES);
        endcase
    end

    phase_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        op_d      = op_q;
        round_d   = round_q;
        score_d   = score_q;
        correct_d = correct_q;
        case (state_q)
            IDLE: if (start) state_d = CLR;
            DONE: if (start) begin
                state_d = CLR;
                score_d = 3'd0;
                round_d = 3'd0;
            end
            CLR: begin
                state_d = GEN;
                first_d = 1'b1;
                op_d    = 4'd0;
            end
            GEN: if (tmr_expire) begin
                if (op_q == LAST_OP) begin
                    state_d = BLANK;
                end else begin
                    op_d    = op_q + 4'd1;
                    first_d = 1'b1;
                end
            end
            BLANK: begin
                state_d = ANSWER;
                first_d = 1'b1;
            end
            ANSWER: if (submit || tmr_expire) state_d = CHECK;
            CHECK: begin
                correct_d = (switch == sum_mod);
                if (correct_d && score_q != 3'd7) score_d = score_q + 3'd1;
                state_d = RESULT;
                first_d = 1'b1;
            end
            RESULT: if (tmr_expire) begin
                if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 3'd1;
                    state_d = CLR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        disp_d = DISP_BLANK;
        led_d  = LED_OFF;
        case (state_d)
            GEN: begin
                disp_d = DISP_OPERAND;
                led_d  = LED_OPERAND;
            end
            ANSWER: disp_d = DISP_SWITCH;
            CHECK:  disp_d = DISP_SUM;
            RESULT: begin
                disp_d = DISP_SUM;
                led_d  = correct_d ? LED_CORRECT : LED_WRONG;
            end
            DONE: begin
                disp_d = DISP_SUM;
                led_d  = (score_d == FULL_SCORE) ? LED_CORRECT : LED_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            first_q   <= 1'b0;
            op_q      <= 4'd0;
            round_q   <= 3'd0;
            score_q   <= 3'd0;
            correct_q <= 1'b0;
            sum_clr   <= 1'b0;
            lfsr_step <= 1'b0;
            disp_sel  <= DISP_BLANK;
            led_mode  <= LED_OFF;
            busy      <= 1'b0;
            game_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            op_q      <= op_d;
            round_q   <= round_d;
            score_q   <= score_d;
            correct_q <= correct_d;
            sum_clr   <= (state_d == CLR);
            lfsr_step <= (state_d == GEN) && first_d;
            disp_sel  <= disp_d;
            led_mode  <= led_d;
            busy      <= !(state_d inside {IDLE, DONE});
            game_done <= (state_d == DONE);
        end
    end

    assign score     = score_q;
    assign round_idx = round_q;
endmodule

// File: tb/tb_math_game_sequencer.sv
// Cycle-accurate check of the round controller against a per-cycle expected trace.
module tb_math_game_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, submit;
    logic [6:0] sw, sm;

    logic       a_clr, a_step, a_busy, a_done;
    logic [1:0] a_disp, a_led;
    logic [2:0] a_score, a_rnd;
    logic       b_clr, b_step, b_busy, b_done;
    logic [1:0] b_disp, b_led;
    logic [2:0] b_score, b_rnd;

    math_game_sequencer u_a (
        .clk(clk), .rst(rst), .start(start), .submit(submit), .switch(sw), .sum_mod(sm),
        .sum_clr(a_clr), .lfsr_step(a_step), .disp_sel(a_disp), .led_mode(a_led),
        .score(a_score), .round_idx(a_rnd), .busy(a_busy), .game_done(a_done)
    );

    math_game_sequencer #(
        .NUM_OPERANDS(2), .SHOW_CYCLES(3), .ANSWER_CYCLES(4), .RESULT_CYCLES(2), .ROUNDS(2)
    ) u_b (
        .clk(clk), .rst(rst), .start(start), .submit(submit), .switch(sw), .sum_mod(sm),
        .sum_clr(b_clr), .lfsr_step(b_step), .disp_sel(b_disp), .led_mode(b_led),
        .score(b_score), .round_idx(b_rnd), .busy(b_busy), .game_done(b_done)
    );

    typedef struct {
        logic       rs, st, sb;
        logic       clr, step;
        logic [1:0] disp, led;
        logic [2:0] score, rnd;
        logic       busy, done;
    } vec_t;

    typedef struct {
        logic [6:0] sw, sm;
        int         ansc;
        logic       sub, st_busy, gen_sub;
        logic [1:0] exp_led;
    } rc_t;

    vec_t  q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    logic  sel   = 1'b0;
    string tag   = "reset";

    task automatic expect_cyc(input logic rs, st, sb, clr, step, input logic [1:0] disp, led,
                              input logic [2:0] sc, rn, input logic bz, dn);
        vec_t v;
        v.rs = rs; v.st = st; v.sb = sb; v.clr = clr; v.step = step;
        v.disp = disp; v.led = led; v.score = sc; v.rnd = rn; v.busy = bz; v.done = dn;
        q.push_back(v);
    endtask

    task automatic expect_zero(input logic rs);
        expect_cyc(rs, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask

    // One full round: CLR, GEN slots, BLANK, ANSWER, CHECK, RESULT.
    task automatic push_round(input int nops, show, ansc, res,
                              input logic sub, stf, stb, gsub, good,
                              input logic [2:0] sc0, rn);
        logic [2:0] sc1;
        sc1 = sc0 + {2'b00, good};
        expect_cyc(1'b0, stf, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, sc0, rn, 1'b1, 1'b0);
        for (int j = 0; j < nops; j++)
            for (int c = 0; c < show; c++)
                expect_cyc(1'b0, stb, gsub, 1'b0, c == 0, 2'd1, 2'd1, sc0, rn, 1'b1, 1'b0);
        expect_cyc(1'b0, stb, gsub, 1'b0, 1'b0, 2'd0, 2'd0, sc0, rn, 1'b1, 1'b0);
        for (int k = 0; k < ansc; k++)
            expect_cyc(1'b0, stb, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, sc0, rn, 1'b1, 1'b0);
        expect_cyc(1'b0, stb, sub, 1'b0, 1'b0, 2'd3, 2'd0, sc0, rn, 1'b1, 1'b0);
        for (int k = 0; k < res; k++)
            expect_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, good ? 2'd2 : 2'd3, sc1, rn, 1'b1, 1'b0);
    endtask

    task automatic run_q();
        vec_t r;
        logic [13:0] act, expv;
        while (q.size() > 0) begin
            r = q.pop_front();
            rst = r.rs; start = r.st; submit = r.sb;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            act = sel ? {b_clr, b_step, b_disp, b_led, b_score, b_rnd, b_busy, b_done}
                      : {a_clr, a_step, a_disp, a_led, a_score, a_rnd, a_busy, a_done};
            expv = {r.clr, r.step, r.disp, r.led, r.score, r.rnd, r.busy, r.done};
            n_cmp++;
            if (act !== expv) begin
                n_err++;
                $display("FAIL %s cyc%0d: got clr/step/disp/led/score/rnd/busy/done=%b/%b/%0d/%0d/%0d/%0d/%b/%b need %b/%b/%0d/%0d/%0d/%0d/%b/%b",
                         tag, cyc, act[13], act[12], act[11:10], act[9:8], act[7:5], act[4:2], act[1], act[0],
                         expv[13], expv[12], expv[11:10], expv[9:8], expv[7:5], expv[4:2], expv[1], expv[0]);
            end
        end
    endtask

    rc_t        tbl_a[4];
    rc_t        tbl_b[2];
    logic [2:0] sc;
    logic       good;

    initial begin
        tbl_a[0] = '{sw: 7'd42,  sm: 7'd42, ansc: 15, sub: 1'b0, st_busy: 1'b0, gen_sub: 1'b0, exp_led: 2'd2};
        tbl_a[1] = '{sw: 7'd43,  sm: 7'd42, ansc: 3,  sub: 1'b1, st_busy: 1'b0, gen_sub: 1'b1, exp_led: 2'd3};
        tbl_a[2] = '{sw: 7'd7,   sm: 7'd7,  ansc: 15, sub: 1'b1, st_busy: 1'b1, gen_sub: 1'b0, exp_led: 2'd2};
        tbl_a[3] = '{sw: 7'd127, sm: 7'd27, ansc: 15, sub: 1'b0, st_busy: 1'b0, gen_sub: 1'b0, exp_led: 2'd3};
        tbl_b[0] = '{sw: 7'd5,   sm: 7'd5,  ansc: 4,  sub: 1'b0, st_busy: 1'b0, gen_sub: 1'b0, exp_led: 2'd2};
        tbl_b[1] = '{sw: 7'd99,  sm: 7'd99, ansc: 2,  sub: 1'b1, st_busy: 1'b0, gen_sub: 1'b0, exp_led: 2'd2};

        rst = 1'b1; start = 1'b0; submit = 1'b0; sw = 7'd0; sm = 7'd0;
        @(negedge clk);
        expect_zero(1'b1);
        expect_zero(1'b1);
        expect_zero(1'b0);
        run_q();

        // Four-round game on the default-parameter instance
        sc = 3'd0;
        for (int i = 0; i < 4; i++) begin
            $sformat(tag, "gameA_r%0d", i);
            sw = tbl_a[i].sw; sm = tbl_a[i].sm;
            good = (tbl_a[i].exp_led == 2'd2);
            push_round(5, 1, tbl_a[i].ansc, 4, tbl_a[i].sub, i == 0, tbl_a[i].st_busy,
                       tbl_a[i].gen_sub, good, sc, 3'(i));
            run_q();
            sc = sc + {2'b00, good};
        end
        tag = "gameA_done";
        expect_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, (sc == 3'd4) ? 2'd2 : 2'd0, sc, 3'd3, 1'b0, 1'b1);
        expect_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, (sc == 3'd4) ? 2'd2 : 2'd0, sc, 3'd3, 1'b0, 1'b1);
        expect_cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        run_q();

        // Reset during the third GEN cycle aborts with no further steps
        tag = "midreset";
        expect_zero(1'b1);
        expect_cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            expect_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 3'd0, 3'd0, 1'b1, 1'b0);
        expect_zero(1'b1);
        for (int k = 0; k < 4; k++) expect_zero(1'b0);
        run_q();

        // Two-round game, three-cycle operand slots, both answers right
        sel = 1'b1;
        tag = "gameB_reset";
        expect_zero(1'b1);
        run_q();
        sc = 3'd0;
        for (int i = 0; i < 2; i++) begin
            $sformat(tag, "gameB_r%0d", i);
            sw = tbl_b[i].sw; sm = tbl_b[i].sm;
            good = (tbl_b[i].exp_led == 2'd2);
            push_round(2, 3, tbl_b[i].ansc, 2, tbl_b[i].sub, i == 0, tbl_b[i].st_busy,
                       tbl_b[i].gen_sub, good, sc, 3'(i));
            run_q();
            sc = sc + {2'b00, good};
        end
        tag = "gameB_done";
        expect_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd2, 3'd2, 3'd1, 1'b0, 1'b1);
        expect_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd2, 3'd2, 3'd1, 1'b0, 1'b1);
        expect_cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        run_q();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
